ps2_cmd_decoder: RTL and testbench
==================================

// Module: ps2_cmd_decoder
// PURPOSE
//   Converts the PS/2 scan-code byte stream into game commands for the Connect-4
//   turn FSM. Sits between the PS/2 receiver and the game logic.
//   Tracks make/break and E0-extended sequences, and keeps one held bit per key.
//   Emits two kinds of output: level commands, held while the key is down, and
//   single-cycle edge pulses. Also flags malformed or stalled sequences.
// PARAMETERS
//   TIMEOUT_CYCLES  2_500_000  max CLOCK_50 cycles allowed between prefix and code byte (50 ms)
//   TMO_W           22         width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//   CLOCK_50           in   1  system clock, 50 MHz
//   Resetn             in   1  asynchronous, active-low reset
//   received_data      in   8  scan-code byte from the PS/2 receiver
//   received_data_en   in   1  1-cycle strobe; received_data is valid this cycle
//   right              out  1  level: D (0x23) or E0 74 (right arrow) held
//   left               out  1  level: A (0x1C) or E0 6B (left arrow) held
//   place              out  1  level: Space (0x29), Enter (0x5A) or E0 72 (down arrow) held
//   right_pulse        out  1  1-cycle pulse on the 0->1 transition of right
//   left_pulse         out  1  1-cycle pulse on the 0->1 transition of left
//   place_pulse        out  1  1-cycle pulse on the 0->1 transition of place
//   restart_pulse      out  1  1-cycle pulse on the make of R (0x2D); typematic repeats give no pulse
//   key_error          out  1  1-cycle pulse on a sequence timeout
//   last_code          out  8  last accepted make code (E0 codes stored without the prefix)
// BEHAVIOUR
//   Reset: every output 0, all held bits 0, state IDLE, timeout counter 0.
//   Bytes are consumed only in cycles where received_data_en=1.
//   Latency: strobe in cycle N -> level, pulse and last_code change visible at N+1.
//   Sequence FSM:
//     IDLE:  F0 -> BRK
//            E0 -> EXT
//            known code -> set its held bit
//            FA, FE, AA or unknown -> ignored, stay IDLE
//     BRK:   known code -> clear its held bit, go IDLE
//            unknown -> IDLE
//            F0 -> stay BRK
//     EXT:   F0 -> EXT_BRK
//            74 / 6B / 72 -> set the arrow held bit, go IDLE
//            E0 -> stay EXT
//            other -> IDLE
//     EXT_BRK: 74 / 6B / 72 -> clear the arrow held bit, go IDLE
//            other -> IDLE
//   Timeout: in BRK, EXT or EXT_BRK the counter increments every cycle with no strobe.
//     On reaching TIMEOUT_CYCLES-1: go IDLE and pulse key_error for 1 cycle.
//     Held bits are unchanged on timeout.
//     The counter clears on any strobe and whenever the state is IDLE.
//   Held bits: seven independent bits — D, Rarrow, A, Larrow, Space, Enter, Darrow.
//     right = D|Rarrow, left = A|Larrow, place = Space|Enter|Darrow.
//     Releasing one of two keys mapped to the same command keeps that level at 1.
//   Typematic: a repeated make of an already-held key is accepted but changes no
//     level, so no pulse is produced. last_code still updates.
//   Pulses: registered rising-edge detect on each level.
//     They never coincide with their own level's previous-cycle value being 1.
//     Different commands may pulse in the same cycle only if their levels rise together,
//     which cannot happen with one byte per strobe.
//   A break code for a key that is not held is a no-op.
//   Mid-sequence reset: the asynchronous clear overrides everything and returns to IDLE.
//     The next byte after reset is decoded from IDLE.
// TESTING
//   1 Strobe 0x23 -> right=1 next cycle, right_pulse high exactly 1 cycle.
//     Then F0, 23 -> right=0 one cycle after the 0x23 strobe.
//   2 Strobe 0x29 three times (typematic) -> a single place_pulse; place stays 1; last_code=0x29.
//   3 Hold D, then E0 74, then release D (F0 23) -> right stays 1.
//     Then E0 F0 74 -> right=0; exactly one right_pulse over the whole sequence.
//   4 Strobe E0 only, then no strobe for TIMEOUT_CYCLES (use 8 in sim)
//     -> key_error 1-cycle pulse; next byte 0x1C decodes as A: left=1.
//   5 Strobe F0 0x55 (unknown), then 0x1C -> left=1, left_pulse once; no error.
//   6 Hold A; assert Resetn=0 asynchronously between F0 and 1C
//     -> all outputs 0 immediately; after release, strobe 1C -> left=1.

Source files
------------

// File: rtl/ps2_cmd_decoder_if.sv
// Scan-code byte stream from the PS/2 receiver to the command decoder.
// The receiver drives the byte and its one-cycle valid strobe.
interface ps2_cmd_decoder_if;
    logic [7:0] received_data;
    logic       received_data_en;

    modport master (
        output received_data,
        output received_data_en
    );

    modport slave (
        input received_data,
        input received_data_en
    );
endinterface

// File: rtl/ps2_cmd_decoder.sv
// PS/2 scan-code to Connect-4 command decoder.
// Tracks make/break/E0 sequences, held keys, level and edge commands.
module ps2_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int TMO_W          = 22
) (
    input  logic                    CLOCK_50,
    input  logic                    Resetn,
    ps2_cmd_decoder_if.slave        rx,
    output logic                    right,
    output logic                    left,
    output logic                    place,
    output logic                    right_pulse,
    output logic                    left_pulse,
    output logic                    place_pulse,
    output logic                    restart_pulse,
    output logic                    key_error,
    output logic [7:0]              last_code
);

    // Held-bit positions; R is tracked only to suppress typematic restarts.
    localparam int K_D  = 0;
    localparam int K_RA = 1;
    localparam int K_A  = 2;
    localparam int K_LA = 3;
    localparam int K_SP = 4;
    localparam int K_EN = 5;
    localparam int K_DA = 6;
    localparam int K_R  = 7;

    localparam logic [7:0] C_BRK = 8'hF0;
    localparam logic [7:0] C_EXT = 8'hE0;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       held;
    logic [7:0]       held_nxt;
    logic [7:0]       base_hit;
    logic [7:0]       ext_hit;
    logic             make_ok;
    logic             timeout;
    logic             right_nxt;
    logic             left_nxt;
    logic             place_nxt;

    wire       en   = rx.received_data_en;
    wire [7:0] data = rx.received_data;

    // Map the incoming byte to a one-hot key for plain and E0 codes.
    always_comb begin
        base_hit = '0;
        ext_hit  = '0;
        case (data)
            8'h23:   base_hit[K_D]  = 1'b1;
            8'h1C:   base_hit[K_A]  = 1'b1;
            8'h29:   base_hit[K_SP] = 1'b1;
            8'h5A:   base_hit[K_EN] = 1'b1;
            8'h2D:   base_hit[K_R]  = 1'b1;
            default: base_hit = '0;
        endcase
        case (data)
            8'h74:   ext_hit[K_RA] = 1'b1;
            8'h6B:   ext_hit[K_LA] = 1'b1;
            8'h72:   ext_hit[K_DA] = 1'b1;
            default: ext_hit = '0;
        endcase
    end

    // Next held bits and make acceptance for the byte in this cycle.
    always_comb begin
        held_nxt = held;
        make_ok  = 1'b0;
        if (en) begin
            unique case (state)
                IDLE: begin
                    held_nxt = held | base_hit;
                    make_ok  = |base_hit;
                end
                BRK:     held_nxt = held & ~base_hit;
                EXT: begin
                    held_nxt = held | ext_hit;
                    make_ok  = |ext_hit;
                end
                EXT_BRK: held_nxt = held & ~ext_hit;
                default: held_nxt = held;
            endcase
        end
        right_nxt = held_nxt[K_D] | held_nxt[K_RA];
        left_nxt  = held_nxt[K_A] | held_nxt[K_LA];
        place_nxt = held_nxt[K_SP] | held_nxt[K_EN] | held_nxt[K_DA];
        timeout   = !en && (state != IDLE) && (tmo_cnt == TMO_LAST);
    end

    // Sequence FSM, stall counter and registered command outputs.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            held          <= '0;
            right         <= 1'b0;
            left          <= 1'b0;
            place         <= 1'b0;
            right_pulse   <= 1'b0;
            left_pulse    <= 1'b0;
            place_pulse   <= 1'b0;
            restart_pulse <= 1'b0;
            key_error     <= 1'b0;
            last_code     <= '0;
        end else begin
            held          <= held_nxt;
            right         <= right_nxt;
            left          <= left_nxt;
            place         <= place_nxt;
            right_pulse   <= right_nxt & ~right;
            left_pulse    <= left_nxt & ~left;
            place_pulse   <= place_nxt & ~place;
            restart_pulse <= held_nxt[K_R] & ~held[K_R];
            key_error     <= timeout;
            if (make_ok)
                last_code <= data;

            if (en || state == IDLE || timeout)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            if (en) begin
                unique case (state)
                    IDLE: begin
                        if (data == C_BRK)
                            state <= BRK;
                        else if (data == C_EXT)
                            state <= EXT;
                    end
                    BRK: begin
                        if (data != C_BRK)
                            state <= IDLE;
                    end
                    EXT: begin
                        if (data == C_BRK)
                            state <= EXT_BRK;
                        else if (data != C_EXT)
                            state <= IDLE;
                    end
                    EXT_BRK: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end else if (timeout) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Randomized and directed bench for ps2_cmd_decoder.
// Expected outputs come from a key-event model of the scan-code rules.
module tb_ps2_cmd_decoder;

    localparam int TMO = 8;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       right, left, place;
    logic       right_pulse, left_pulse, place_pulse;
    logic       restart_pulse, key_error;
    logic [7:0] last_code;

    ps2_cmd_decoder_if ifc ();

    ps2_cmd_decoder #(
        .TIMEOUT_CYCLES(TMO),
        .TMO_W(4)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .Resetn(Resetn),
        .rx(ifc.slave),
        .right(right),
        .left(left),
        .place(place),
        .right_pulse(right_pulse),
        .left_pulse(left_pulse),
        .place_pulse(place_pulse),
        .restart_pulse(restart_pulse),
        .key_error(key_error),
        .last_code(last_code)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    // Reference model: held keys, pending prefix flags, idle count.
    bit [7:0]   m_held;
    bit         m_brk;
    bit         m_ext;
    int         m_idle;
    logic [7:0] m_last;
    bit [2:0]   m_lvl;
    logic [7:0] exp_flags;

    int n_rp, n_pp, n_lp, n_err;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int key_of(logic [7:0] c, bit ext);
        if (!ext) begin
            case (c)
                8'h23:   return 0;
                8'h1C:   return 2;
                8'h29:   return 4;
                8'h5A:   return 5;
                8'h2D:   return 7;
                default: return -1;
            endcase
        end
        case (c)
            8'h74:   return 1;
            8'h6B:   return 3;
            8'h72:   return 6;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_held    = '0;
        m_brk     = 0;
        m_ext     = 0;
        m_idle    = 0;
        m_last    = '0;
        m_lvl     = '0;
        exp_flags = '0;
    endtask

    task automatic model_step(bit en, logic [7:0] b);
        bit       err;
        bit       r_before;
        int       k;
        bit [2:0] lv;
        err      = 0;
        r_before = m_held[7];
        if (en) begin
            m_idle = 0;
            k = key_of(b, m_ext);
            if (!m_brk && !m_ext) begin
                if (b == 8'hF0) m_brk = 1;
                else if (b == 8'hE0) m_ext = 1;
                else if (k >= 0) begin
                    m_held[k] = 1;
                    m_last = b;
                end
            end else if (m_brk && !m_ext) begin
                if (b != 8'hF0) begin
                    if (k >= 0) m_held[k] = 0;
                    m_brk = 0;
                end
            end else if (!m_brk && m_ext) begin
                if (b == 8'hF0) m_brk = 1;
                else if (b != 8'hE0) begin
                    if (k >= 0) begin
                        m_held[k] = 1;
                        m_last = b;
                    end
                    m_ext = 0;
                end
            end else begin
                if (k >= 0) m_held[k] = 0;
                m_brk = 0;
                m_ext = 0;
            end
        end else if (m_brk || m_ext) begin
            m_idle++;
            if (m_idle == TMO) begin
                err    = 1;
                m_brk  = 0;
                m_ext  = 0;
                m_idle = 0;
            end
        end
        lv = {m_held[0] | m_held[1],
              m_held[2] | m_held[3],
              m_held[4] | m_held[5] | m_held[6]};
        exp_flags = {lv, lv & ~m_lvl, m_held[7] & ~r_before, err};
        m_lvl = lv;
    endtask

    task automatic check_all(string tag);
        chk({tag, " flags"},
            {24'd0, right, left, place, right_pulse, left_pulse,
             place_pulse, restart_pulse, key_error},
            {24'd0, exp_flags});
        chk({tag, " code"}, {24'd0, last_code}, {24'd0, m_last});
    endtask

    task automatic cyc(bit en, logic [7:0] b, string tag);
        ifc.received_data_en = en;
        ifc.received_data    = en ? b : 8'($urandom);
        @(posedge CLOCK_50);
        #1;
        ifc.received_data_en = 1'b0;
        model_step(en, b);
        check_all(tag);
        n_rp  += int'(right_pulse);
        n_lp  += int'(left_pulse);
        n_pp  += int'(place_pulse);
        n_err += int'(key_error);
    endtask

    task automatic do_reset(string tag);
        #3;
        Resetn = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge CLOCK_50);
        #4;
        Resetn = 1'b1;
        n_rp  = 0;
        n_lp  = 0;
        n_pp  = 0;
        n_err = 0;
    endtask

    logic [7:0] pool [14];

    initial begin
        ifc.received_data_en = 1'b0;
        ifc.received_data    = 8'h00;
        model_reset();
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_all("reset");
        #4;
        Resetn = 1'b1;

        // 1: D make then break
        do_reset("t1 rst");
        cyc(1, 8'h23, "t1 make");
        chk("t1 right", {31'd0, right}, 1);
        cyc(0, 8'h00, "t1 gap");
        cyc(1, 8'hF0, "t1 f0");
        cyc(1, 8'h23, "t1 brk");
        chk("t1 right off", {31'd0, right}, 0);
        chk("t1 pulses", n_rp, 1);

        // 2: Space typematic
        do_reset("t2 rst");
        repeat (3) cyc(1, 8'h29, "t2 rep");
        chk("t2 place", {31'd0, place}, 1);
        chk("t2 pulses", n_pp, 1);
        chk("t2 code", {24'd0, last_code}, 32'h29);

        // 3: D and right arrow overlap
        do_reset("t3 rst");
        cyc(1, 8'h23, "t3 d");
        cyc(1, 8'hE0, "t3 e0");
        cyc(1, 8'h74, "t3 ra");
        cyc(1, 8'hF0, "t3 f0");
        cyc(1, 8'h23, "t3 dbrk");
        chk("t3 right held", {31'd0, right}, 1);
        cyc(1, 8'hE0, "t3 e0b");
        cyc(1, 8'hF0, "t3 f0b");
        cyc(1, 8'h74, "t3 rabrk");
        chk("t3 right off", {31'd0, right}, 0);
        chk("t3 pulses", n_rp, 1);

        // 4: stalled prefix times out
        do_reset("t4 rst");
        cyc(1, 8'hE0, "t4 e0");
        repeat (TMO + 3) cyc(0, 8'h00, "t4 idle");
        chk("t4 errs", n_err, 1);
        cyc(1, 8'h1C, "t4 a");
        chk("t4 left", {31'd0, left}, 1);

        // 5: break of unknown code
        do_reset("t5 rst");
        cyc(1, 8'hF0, "t5 f0");
        cyc(1, 8'h55, "t5 unk");
        cyc(1, 8'h1C, "t5 a");
        cyc(0, 8'h00, "t5 gap");
        chk("t5 left", {31'd0, left}, 1);
        chk("t5 pulses", n_lp, 1);
        chk("t5 errs", n_err, 0);

        // 6: async reset mid-sequence
        do_reset("t6 rst");
        cyc(1, 8'h1C, "t6 a");
        cyc(1, 8'hF0, "t6 f0");
        do_reset("t6 async");
        cyc(1, 8'h1C, "t6 a2");
        chk("t6 left", {31'd0, left}, 1);

        // Restart key: make, repeat, break, make
        do_reset("r rst");
        cyc(1, 8'h2D, "r make");
        cyc(1, 8'h2D, "r rep");
        cyc(1, 8'hF0, "r f0");
        cyc(1, 8'h2D, "r brk");
        cyc(1, 8'h2D, "r make2");

        // Random byte stream with idle gaps
        pool = '{8'h23, 8'h74, 8'h1C, 8'h6B, 8'h29, 8'h5A, 8'h72,
                 8'h2D, 8'hF0, 8'hE0, 8'hFA, 8'hAA, 8'h55, 8'hF0};
        do_reset("rnd rst");
        for (int i = 0; i < 1500; i++) begin
            cyc(1, pool[$urandom_range(0, 13)], "rnd byte");
            if ($urandom_range(0, 9) == 0)
                repeat (TMO + 2) cyc(0, 8'h00, "rnd stall");
            else
                repeat ($urandom_range(0, 3)) cyc(0, 8'h00, "rnd gap");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
